viterbi_tb_unit: RTL and testbench
==================================

# viterbi_tb_unit

Parametrised traceback unit for the Viterbi decoder: generalises the fixed 4-state traceback to any constraint length, traceback depth and metric width. Sits after the ACS array, accepts one trellis column per handshake (per-state survivor decisions plus path metrics), buffers a frame, traces back from the minimum-metric state, and emits decoded bits in forward order over a valid/ready stream with frame delimiting and backpressure.

## Interface
Parameters
- CONSTR_LEN, 3, constraint length K (≥3); M = K-1 state bits, NUM_STATES = 2^M
- TB_DEPTH, 16, max columns per frame (≥2); CNT_W = $clog2(TB_DEPTH+1)
- METRIC_W, 4, unsigned path-metric width

Ports
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  column present
- in_ready  out  1  unit accepts a column
- surv_i  in  NUM_STATES  bit s = survivor decision of state s
- metric_i  in  NUM_STATES*METRIC_W  metric of state s at bits [s*METRIC_W +: METRIC_W]
- in_last  in  1  accepted column is the frame's final column
- out_valid  out  1  d_out valid
- out_ready  in  1  downstream accepts d_out
- d_out  out  1  decoded bit, forward order
- out_last  out  1  final bit of frame
- busy  out  1  high in TRACE or DRAIN
- tb_cnt  out  CNT_W  phase counter (see Operation)

## Operation
- Trellis convention: next state = {u, s[M-1:1]}; predecessor of s with survivor b = {s[M-2:0], b}; decoded bit at s = s[M-1].
- Survivor memory: TB_DEPTH × NUM_STATES bits; bit buffer: TB_DEPTH bits.
- FSM states FILL, TRACE, DRAIN; reset → FILL.
- FILL: in_ready=1. Accept (in_valid & in_ready) writes surv_i to column wr_ptr, wr_ptr++. Column closes the frame if in_last=1 or wr_ptr==TB_DEPTH-1 (auto-close, in_last ignored thereafter). On close: frame_len = wr_ptr+1, start state = argmin(metric_i) of that closing column (unsigned compare, ties → lowest index), idx = frame_len-1, → TRACE.
- TRACE: in_ready=0. Each cycle: bit[idx] = s[M-1]; s ← {s[M-2:0], surv[idx][s]}; idx--. After idx==0 → DRAIN. Exactly frame_len cycles.
- DRAIN: out_valid=1, d_out=bit[rd], out_last=(rd==frame_len-1). On out_valid&out_ready rd++; after last bit → FILL, wr_ptr=rd=0.
- tb_cnt: FILL = columns stored; TRACE = idx+1 remaining; DRAIN = frame_len-rd bits remaining.
- No column is accepted while busy; no output while in FILL.

## Timing
- Reset values: in_ready=1, out_valid=0, d_out=0, out_last=0, busy=0, tb_cnt=0; pointers and start state 0.
- Closing column accepted at edge T → TRACE cycles T+1..T+L (L=frame_len) → out_valid=1 from cycle after edge T+L; first bit then L handshakes.
- d_out/out_last held stable while out_valid=1 and out_ready=0.
- in_ready falls the cycle after the closing accept; returns the cycle after the last output handshake.
- Reset asserted mid-frame (any state) discards stored columns and partial output; no out_valid after release until a new frame closes.
- Frame of length 1 valid: TRACE 1 cycle, single bit with out_last=1.

## Configuration
- TBU_ZERO_START_EN: defined → traceback always starts at state 0 (terminated trellis), metric_i ignored and argmin logic removed. Undefined → start state is argmin of closing column metrics as above.

## Test plan
- K=3, surv_i=0000, metrics {s0..s3}={0,3,3,3}, 5 columns, in_last on 5th → out bits 0,0,0,0,0, out_last on 5th, first out_valid 5 cycles after closing accept.
- K=3, surv_i=0000, metrics min at state 2 ({3,3,0,3}), 4 columns → out 0,0,0,1; tb_cnt counts 4,3,2,1 during DRAIN.
- K=3, surv_i=1111, all metrics equal (tie → state 0), 4 columns → out 1,1,0,0.
- 16 columns, in_last never asserted → auto-close at 16th, 16 outputs, out_last on 16th, in_ready=0 throughout TRACE/DRAIN.
- out_ready held low 3 cycles mid-DRAIN → d_out/out_last stable, no bit lost; rst pulsed during TRACE → all outputs to reset values, next 2-column frame decodes correctly.
- With TBU_ZERO_START_EN: metrics {3,3,0,3}, surv_i=0000, 4 columns → out 0,0,0,0.

Source files
------------

// File: rtl/viterbi_tb_unit.sv
// Parametrised Viterbi traceback unit: buffers one frame of survivor columns, traces back, streams bits in forward order.
// Optional macro TBU_ZERO_START_EN: traceback always starts at state 0 and the metric inputs are ignored.
module viterbi_tb_unit #(
  parameter int CONSTR_LEN = 3,
  parameter int TB_DEPTH   = 16,
  parameter int METRIC_W   = 4,
  localparam int M          = CONSTR_LEN - 1,
  localparam int NUM_STATES = 1 << M,
  localparam int CNT_W      = $clog2(TB_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_STATES-1:0]          surv_i,
  input  logic [NUM_STATES*METRIC_W-1:0] metric_i,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           d_out,
  output logic                           out_last,
  output logic                           busy,
  output logic [CNT_W-1:0]               tb_cnt
);

  localparam int AW = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TB_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {FILL, TRACE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    frame_len_q, frame_len_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    rd_q, rd_d;
  logic [M-1:0]        s_q, s_d;
  logic [TB_DEPTH-1:0] bit_buf_q, bit_buf_d;
  logic [NUM_STATES-1:0] surv_mem [TB_DEPTH];
  logic                surv_we;
  logic [NUM_STATES-1:0] surv_col;
  logic [M-1:0]        start_state;

  // Lowest-index state holding the smallest unsigned metric.
  function automatic logic [M-1:0] argmin_state(input logic [NUM_STATES*METRIC_W-1:0] m);
    logic [METRIC_W-1:0] best;
    logic [M-1:0]        sel;
    best = m[METRIC_W-1:0];
    sel  = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (m[s*METRIC_W +: METRIC_W] < best) begin
        best = m[s*METRIC_W +: METRIC_W];
        sel  = M'(s);
      end
    end
    return sel;
  endfunction

`ifdef TBU_ZERO_START_EN
  logic unused_metric;
  assign unused_metric = ^metric_i;
  assign start_state   = '0;
`else
  assign start_state = argmin_state(metric_i);
`endif

  assign surv_col = surv_mem[idx_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_len_d = frame_len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    s_d         = s_q;
    bit_buf_d   = bit_buf_q;
    surv_we     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    d_out       = 1'b0;
    out_last    = 1'b0;
    tb_cnt      = '0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        tb_cnt   = wr_ptr_q;
        if (in_valid) begin
          surv_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
          if (in_last || wr_ptr_q == LAST_COL) begin
            frame_len_d = wr_ptr_q + ONE;
            idx_d       = wr_ptr_q;
            s_d         = start_state;
            state_d     = TRACE;
          end
        end
      end
      TRACE: begin
        // Decoded bit is the MSB of the current state; walk to its predecessor.
        tb_cnt                    = idx_q + ONE;
        bit_buf_d[idx_q[AW-1:0]]  = s_q[M-1];
        s_d                       = {s_q[M-2:0], surv_col[s_q]};
        if (idx_q == '0) begin
          rd_d    = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q - ONE;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        d_out     = bit_buf_q[rd_q[AW-1:0]];
        out_last  = (rd_q == frame_len_q - ONE);
        tb_cnt    = frame_len_q - rd_q;
        if (out_ready) begin
          if (out_last) begin
            wr_ptr_d = '0;
            rd_d     = '0;
            state_d  = FILL;
          end else begin
            rd_d = rd_q + ONE;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign busy = (state_q != FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      frame_len_q <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_len_q <= frame_len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      s_q         <= s_d;
    end
  end

  // Storage is never read before being rewritten within a frame, so it carries no reset.
  always_ff @(posedge clk) begin
    bit_buf_q <= bit_buf_d;
    if (surv_we) surv_mem[wr_ptr_q[AW-1:0]] <= surv_i;
  end

endmodule

// File: tb/tb_viterbi_tb_unit.sv
// Directed bench for viterbi_tb_unit (K=3, depth 16) with an expected-bit queue.
module tb_viterbi_tb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  surv_i = '0;
  logic [15:0] metric_i = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        d_out;
  logic        out_last;
  logic        busy;
  logic [4:0]  tb_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] sb [$];
  logic [3:0] mc_surv [16];

  viterbi_tb_unit #(.CONSTR_LEN(3), .TB_DEPTH(16), .METRIC_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .surv_i(surv_i), .metric_i(metric_i), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .out_last(out_last), .busy(busy), .tb_cnt(tb_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_d_out"},     d_out,     0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_tb_cnt"},    tb_cnt,    0);
  endtask

  task automatic send_col(input logic [3:0] s, input logic [15:0] m, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    surv_i   = s;
    metric_i = m;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference traceback over the columns held in mc_surv.
  function automatic void model_push(input int len, input logic [15:0] met);
    logic [1:0] s;
    logic [3:0] best;
    logic       b [16];
    s = 2'd0;
`ifndef TBU_ZERO_START_EN
    best = met[3:0];
    for (int st = 1; st < 4; st++) begin
      if (met[st*4 +: 4] < best) begin
        best = met[st*4 +: 4];
        s    = 2'(st);
      end
    end
`endif
    for (int i = len - 1; i >= 0; i--) begin
      b[i] = s[1];
      s    = {s[0], mc_surv[i][s]};
    end
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), b[i]});
  endfunction

  task automatic send_random_frame(input int len, input logic use_last);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < len; i++) begin
      mc_surv[i] = 4'($urandom_range(0, 15));
      m          = 16'($urandom);
      send_col(mc_surv[i], m, use_last && (i == len - 1));
    end
    model_push(len, m);
  endtask

  task automatic wait_valid(input string tag, input int len);
    int lat;
    chk({tag, "_busy"},     busy,     1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_tb_cnt0"},  tb_cnt,   len);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, len);
  endtask

  task automatic drain(input string tag, input int stall_at);
    int   n, got, cyc;
    logic stalled, hold_d, hold_l;
    logic [1:0] e;
    n = sb.size();
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    while (got < n && cyc < 500) begin
      if (got == stall_at && !stalled && out_valid) begin
        stalled   = 1'b1;
        hold_d    = d_out;
        hold_l    = out_last;
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk({tag, "_stall_valid"}, out_valid, 1);
          chk({tag, "_stall_d"},     d_out,     hold_d);
          chk({tag, "_stall_last"},  out_last,  hold_l);
        end
      end
      out_ready = 1'b1;
      if (out_valid) begin
        e = sb.pop_front();
        chk({tag, "_d_out"},    d_out,    e[0]);
        chk({tag, "_out_last"}, out_last, e[1]);
        chk({tag, "_tb_cnt"},   tb_cnt,   n - got);
        chk({tag, "_in_ready"}, in_ready, 0);
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (got < n) chk({tag, "_drain_timeout"}, got, n);
    chk({tag, "_post_valid"},    out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready,  1);
    out_ready = 1'b0;
  endtask

  initial begin
    int vcnt;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // 5-column all-zero survivors, minimum at state 0.
    for (int i = 0; i < 5; i++) begin
      send_col(4'h0, 16'h3330, i == 4);
      if (i == 1) chk("t1_fill_cnt", tb_cnt, 2);
    end
    for (int i = 0; i < 5; i++) sb.push_back({(i == 4), 1'b0});
    wait_valid("t1", 5);
    drain("t1", -1);

    // Minimum at state 2, with a 3-cycle output stall mid-frame.
    for (int i = 0; i < 4; i++) send_col(4'h0, 16'h3033, i == 3);
`ifdef TBU_ZERO_START_EN
    sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b10);
`else
    sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b11);
`endif
    wait_valid("t2", 4);
    drain("t2", 2);

    // All survivors set, tied metrics resolve to state 0.
    for (int i = 0; i < 4; i++) send_col(4'hF, 16'h5555, i == 3);
    sb.push_back(2'b01); sb.push_back(2'b01); sb.push_back(2'b00); sb.push_back(2'b10);
    wait_valid("t3", 4);
    drain("t3", -1);

    // Full-depth frame closed automatically.
    send_random_frame(16, 1'b0);
    wait_valid("t4", 16);
    drain("t4", 5);

    // Reset pulsed during TRACE discards the frame.
    for (int i = 0; i < 4; i++) send_col(4'hA, 16'h1234, i == 3);
    @(posedge clk);
    #1;
    chk("t5_in_trace", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    chk("t5_no_valid", vcnt, 0);
    send_random_frame(2, 1'b1);
    wait_valid("t5b", 2);
    drain("t5b", -1);

    // Single-column frame.
    mc_surv[0] = 4'h0;
    send_col(4'h0, 16'h3033, 1'b1);
    model_push(1, 16'h3033);
    wait_valid("t6", 1);
    drain("t6", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
